// File: rtl/viterbi_pkg.sv
// Shared types and constants for the Viterbi loopback link controller.
// Holds the frame FSM states, LFSR constants and a saturating counter helper.
package viterbi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        FLUSH,
        DRAIN,
        DONE
    } state_t;

    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // Feedback taps on bits 0,2,3,5 of a right-shifting LFSR: x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/viterbi_link_ctrl_if.sv
// Frame control, encoder/channel drive and result signals of the link controller.
// The slave modport is the controller side, the master modport the system side.
interface viterbi_link_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             start_i;
    logic [15:0]      seed_i;
    logic [4:0]       inj_period_i;
    logic             enc_bit_o;
    logic             enc_en_o;
    logic [1:0]       inj_mask_o;
    logic             dec_bit_i;
    logic             busy_o;
    logic             done_o;
    logic [CNT_W-1:0] bit_err_ct_o;
    logic [CNT_W-1:0] inj_ct_o;

    modport slave (
        input  start_i, seed_i, inj_period_i, dec_bit_i,
        output enc_bit_o, enc_en_o, inj_mask_o, busy_o, done_o, bit_err_ct_o, inj_ct_o
    );

    modport master (
        output start_i, seed_i, inj_period_i, dec_bit_i,
        input  enc_bit_o, enc_en_o, inj_mask_o, busy_o, done_o, bit_err_ct_o, inj_ct_o
    );
endinterface

// File: rtl/prbs16.sv
// 16-bit Fibonacci PRBS generator producing the payload bit stream.
// A zero seed would lock the register, so it is replaced by the default seed.
module prbs16
    import viterbi_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        advance,
    output logic        bit_o
);

    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= LFSR_DEFAULT_SEED;
        end else if (load) begin
            lfsr <= (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
        end else if (advance) begin
            lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
        end
    end

    assign bit_o = lfsr[0];

endmodule

// File: rtl/viterbi_link_ctrl.sv
// Frame sequencer for the encoder -> channel -> Viterbi decoder loopback:
// sends a PRBS frame plus flush tail, injects channel errors, and counts decode errors.
module viterbi_link_ctrl
    import viterbi_pkg::*;
#(
    parameter int FRAME_LEN = 256,
    parameter int TAIL      = 2,
    parameter int ENC_LAT   = 1,
    parameter int DEC_LAT   = 16,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    viterbi_link_ctrl_if.slave link
);

    localparam int MAX_A   = (FRAME_LEN > TAIL) ? FRAME_LEN : TAIL;
    localparam int MAX_LEN = (MAX_A > DEC_LAT) ? MAX_A : DEC_LAT;
    localparam int IDX_W   = $clog2(MAX_LEN + 1);

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;
    logic               accept;
    logic               enc_en;
    logic               enc_bit;
    logic               busy;
    logic               done;
    logic               prbs_bit;

    logic [4:0]         period_q;
    logic [4:0]         word_cnt;
    logic               inj_hit;
    logic [ENC_LAT-1:0] inj_pipe;
    logic [CNT_W-1:0]   inj_ct;
    logic [CNT_W-1:0]   err_ct;

    logic [DEC_LAT-1:0] dl_valid;
    logic [DEC_LAT-1:0] dl_bit;
    logic               dl_mismatch;

    prbs16 u_prbs (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .seed    (link.seed_i),
        .advance (state == SEND),
        .bit_o   (prbs_bit)
    );

    // The phase index restarts whenever the FSM changes state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state || state == IDLE) begin
                idx <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        enc_en    = 1'b0;
        enc_bit   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (link.start_i) begin
                    accept    = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                enc_en  = 1'b1;
                enc_bit = prbs_bit;
                if (idx == IDX_W'(FRAME_LEN - 1)) state_nxt = FLUSH;
            end
            FLUSH: begin
                enc_en = 1'b1;
                if (idx == IDX_W'(TAIL - 1)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (idx == IDX_W'(DEC_LAT - 1)) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign inj_hit     = enc_en && (period_q != 5'd0) && (word_cnt == period_q - 5'd1);
    assign dl_mismatch = dl_valid[DEC_LAT-1] && (link.dec_bit_i != dl_bit[DEC_LAT-1]);

    // Counters clear on an accepted start and otherwise hold between frames
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_q <= '0;
            word_cnt <= '0;
            inj_ct   <= '0;
            err_ct   <= '0;
        end else if (accept) begin
            period_q <= link.inj_period_i;
            word_cnt <= '0;
            inj_ct   <= '0;
            err_ct   <= '0;
        end else begin
            if (enc_en) word_cnt <= inj_hit ? 5'd0 : word_cnt + 5'd1;
            if (inj_hit) inj_ct <= CNT_W'(sat_inc(32'(inj_ct), CNT_W));
            if (dl_mismatch) err_ct <= CNT_W'(sat_inc(32'(err_ct), CNT_W));
        end
    end

    // Injection mask trails the encoder input by the encoder latency;
    // the delay line holds every sent bit until its decoded copy arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inj_pipe <= '0;
            dl_valid <= '0;
            dl_bit   <= '0;
        end else begin
            inj_pipe <= ENC_LAT'({inj_pipe, inj_hit});
            dl_valid <= DEC_LAT'({dl_valid, enc_en && (state == SEND)});
            dl_bit   <= DEC_LAT'({dl_bit, enc_en && enc_bit});
        end
    end

    assign link.enc_en_o     = enc_en;
    assign link.enc_bit_o    = enc_bit;
    assign link.busy_o       = busy;
    assign link.done_o       = done;
    assign link.inj_mask_o   = {2{inj_pipe[ENC_LAT-1]}};
    assign link.inj_ct_o     = inj_ct;
    assign link.bit_err_ct_o = err_ct;

endmodule

// File: doc/viterbi_link_ctrl.md
Name: viterbi_link_ctrl

Overview:
Frame-level sequencer for the convolutional encoder -> channel -> Viterbi decoder loopback.
- On start, generates a PRBS payload frame, drives the encoder bit by bit, then appends zero tail bits to flush the trellis.
- Drives a programmable 2-bit error-injection mask that the channel XORs onto encoder output.
- Compares decoder output against a latency-matched copy of the sent bits, and reports bit-error and injection counts when the frame completes.

Parameters:
- FRAME_LEN, 256, payload bits per frame (>=1).
- TAIL, 2, zero flush bits appended after payload (K-1).
- ENC_LAT, 1, cycles from enc_en_o/enc_bit_o to the matching encoder output word.
- DEC_LAT, 16, cycles from enc_en_o of a bit to decoder output of that bit on dec_bit_i (>=ENC_LAT+1).
- CNT_W, 16, width of the result counters.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset, asynchronous, active-low.
- start_i, input, 1, single-cycle frame start request.
- seed_i, input, 16, PRBS seed, sampled on an accepted start.
- inj_period_i, input, 5, injection period in encoded words; 0 disables injection. Sampled on an accepted start.
- enc_bit_o, output, 1, data bit to the encoder.
- enc_en_o, output, 1, encoder enable: one bit per cycle while high.
- inj_mask_o, output, 2, XOR mask for the encoder output word.
- dec_bit_i, input, 1, decoder output bit.
- busy_o, output, 1, frame in progress.
- done_o, output, 1, one-cycle pulse at frame end.
- bit_err_ct_o, output, CNT_W, payload bit mismatches in the last or current frame.
- inj_ct_o, output, CNT_W, injection events in the last or current frame.

Behaviour:
- Reset values: all outputs 0. FSM in IDLE. LFSR=16'hACE1. Delay line cleared. Reset mid-frame aborts the frame; the first cycle after reset release is IDLE with enc_en_o=0.
- FSM states: IDLE, SEND, FLUSH, DRAIN, DONE.
- IDLE: start_i=1 -> SEND. On that edge:
  - Load LFSR with seed_i, or 16'hACE1 if seed_i==0.
  - Latch inj_period_i.
  - Clear both counters, the injection counter and the bit index.
  - busy_o=1 from the next cycle until the DONE cycle inclusive.
- start_i is ignored in every state other than IDLE.
- SEND: FRAME_LEN cycles.
  - enc_en_o=1, enc_bit_o=lfsr[0].
  - LFSR advances each cycle: shift right, new msb = lfsr[0]^lfsr[2]^lfsr[3]^lfsr[5] (x^16+x^14+x^13+x^11+1).
  - After the last payload bit -> FLUSH.
- FLUSH: TAIL cycles, enc_en_o=1, enc_bit_o=0 -> DRAIN.
- DRAIN: DEC_LAT cycles, enc_en_o=0 -> DONE.
- DONE: one cycle, done_o=1 -> IDLE. Counters hold their values until the next accepted start.
- No idle cycles are inserted between SEND and FLUSH.
- Total: start accepted at edge 0 gives enc_en_o high for cycles 1..FRAME_LEN+TAIL. done_o is high in cycle FRAME_LEN+TAIL+DEC_LAT+1.
- Injection:
  - Word counter increments on each enc_en_o cycle and wraps at period-1.
  - When period!=0 and the counter equals period-1, inj_mask_o=2'b11 exactly ENC_LAT cycles later, and inj_ct_o increments. Otherwise inj_mask_o=2'b00.
  - Period 1 injects on every word.
  - Tail bits are injectable.
- Checking:
  - A delay line of depth DEC_LAT carries {payload_valid, bit} for each enc_en_o cycle. Tail bits carry payload_valid=0.
  - When the delay-line output is valid and dec_bit_i differs from the delayed bit, bit_err_ct_o increments.
  - Exactly FRAME_LEN comparisons occur per frame.
- Counters saturate at all-ones; there is no wrap.

Decomposition:
- Package viterbi_pkg holds:
  - state enum state_t {IDLE,SEND,FLUSH,DRAIN,DONE};
  - LFSR_DEFAULT_SEED=16'hACE1;
  - LFSR tap constant;
  - a saturating-increment function.
- Sub-module prbs16: load, seed, advance, bit output, instantiated once. The delay line and counters stay inline.

Test Plan:
1. seed_i=16'h1234, inj_period_i=0, ideal decoder model -> enc_en_o high for 258 cycles, done_o at cycle 275, bit_err_ct_o=0, inj_ct_o=0.
2. inj_period_i=16 with the real encoder and decoder -> inj_ct_o=16 (258/16), bit_err_ct_o=0, with inj_mask_o=2'b11 one cycle after the 16th, 32nd, ... enc_en_o cycles.
3. inj_period_i=1 -> inj_ct_o=258 and bit_err_ct_o equal to the scoreboard mismatch count (nonzero). Decoder stubbed to invert every bit -> bit_err_ct_o=256.
4. seed_i=0 versus seed_i=16'hACE1 -> identical enc_bit_o streams. First 4 bits match the reference LFSR model.
5. start_i pulsed during SEND and again in the DONE cycle -> both ignored, a single done_o pulse, counters unchanged. start_i after return to IDLE clears the counters and begins a new frame.
6. rst low at cycle 100 of SEND -> all outputs 0 asynchronously. After release: IDLE, enc_en_o=0, no done_o until a new start_i.
